// File: rtl/sym_serializer.sv
// -----------------------------------------------------------------------------
// sym_serializer
//
// Pops WIDTH-bit words from an upstream synchronous FIFO and emits each word
// as WIDTH/SYM_BITS symbols of SYM_BITS bits, most-significant symbol first,
// using a valid/ready handshake towards the modulator.
//
// Ports
//   CLK         in   1         clock, all state changes on rising edge
//   RST         in   1         synchronous active-high reset
//   fifo_empty  in   1         upstream FIFO empty flag
//   fifo_rEN    out  1         one-cycle FIFO read pulse
//   fifo_dOut   in   WIDTH     FIFO read data, valid the cycle after fifo_rEN
//   sym_out     out  SYM_BITS  current symbol
//   sym_valid   out  1         sym_out holds a valid symbol
//   sym_ready   in   1         modulator accepts the symbol this cycle
//   busy        out  1         FSM is not idle
//   starve_cnt  out  16        (only with SYM_SERIALIZER_STARVE_CNT_EN) number of
//                              words that finished with the FIFO empty, saturating
//
// Build option
//   SYM_SERIALIZER_STARVE_CNT_EN : when defined, adds the starve_cnt output.
// -----------------------------------------------------------------------------
module sym_serializer #(
  parameter int WIDTH    = 16,
  parameter int SYM_BITS = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                fifo_empty,
  output logic                fifo_rEN,
  input  logic [WIDTH-1:0]    fifo_dOut,
  output logic [SYM_BITS-1:0] sym_out,
  output logic                sym_valid,
  input  logic                sym_ready,
  output logic                busy
`ifdef SYM_SERIALIZER_STARVE_CNT_EN
  ,
  output logic [15:0]         starve_cnt
`endif
);

  localparam int NSYM  = WIDTH / SYM_BITS;
  localparam int CNT_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NSYM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    SHIFT = 2'd3
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [WIDTH-1:0]   shreg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rd_en_q;
  logic               valid_q;
  logic               busy_q;
  logic               xfer_s;
  logic               last_s;

  // Handshake decode and next-state logic; fifo_empty is only looked at in
  // IDLE and on the last-symbol transfer so a mid-word empty has no effect.
  always_comb begin
    xfer_s  = (state_q == SHIFT) && sym_ready;
    last_s  = xfer_s && (cnt_q == {CNT_W{1'b0}});
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = REQ;
        else             state_d = IDLE;
      end
      REQ:  state_d = WAIT;
      WAIT: state_d = SHIFT;
      SHIFT: begin
        if (last_s) state_d = fifo_empty ? IDLE : REQ;
        else        state_d = SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, datapath and registered outputs. Outputs are decoded from the
  // next state so they change together with the state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      shreg_q <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_en_q <= (state_d == REQ);
      valid_q <= (state_d == SHIFT);
      busy_q  <= (state_d != IDLE);
      if (state_q == WAIT) begin
        // FIFO data requested in REQ is valid now.
        shreg_q <= fifo_dOut;
        cnt_q   <= CNT_LOAD;
      end else if (xfer_s) begin
        shreg_q <= shreg_q << SYM_BITS;
        // Counter stops at zero; the next word reloads it in WAIT.
        if (!last_s) cnt_q <= cnt_q - CNT_W'(1);
        else         cnt_q <= cnt_q;
      end else begin
        shreg_q <= shreg_q;
        cnt_q   <= cnt_q;
      end
    end
  end

  assign fifo_rEN  = rd_en_q;
  assign sym_valid = valid_q;
  assign busy      = busy_q;
  assign sym_out   = shreg_q[WIDTH-1 -: SYM_BITS];

`ifdef SYM_SERIALIZER_STARVE_CNT_EN
  logic [15:0] starve_q;

  // Count words whose last symbol left while the FIFO had nothing more.
  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_q <= 16'h0000;
    end else if (last_s && fifo_empty && (starve_q != 16'hFFFF)) begin
      starve_q <= starve_q + 16'h0001;
    end else begin
      starve_q <= starve_q;
    end
  end

  assign starve_cnt = starve_q;
`endif

endmodule

// File: tb/tb_sym_serializer.sv
module tb_sym_serializer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        fifo_empty;
  logic        fifo_rEN;
  logic [15:0] fifo_dOut = 16'h0000;
  logic [1:0]  sym_out;
  logic        sym_valid;
  logic        sym_ready;
  logic        busy;
`ifdef SYM_SERIALIZER_STARVE_CNT_EN
  logic [15:0] starve_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Simple FIFO model: words are pushed by the stimulus, popped on fifo_rEN.
  logic [15:0] mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int ren_cnt = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (fifo_rEN) begin
      ren_cnt <= ren_cnt + 1;
      if (rd_ptr != wr_ptr) begin
        fifo_dOut <= mem[rd_ptr % 32];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  sym_serializer #(.WIDTH(16), .SYM_BITS(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .fifo_empty (fifo_empty),
    .fifo_rEN   (fifo_rEN),
    .fifo_dOut  (fifo_dOut),
    .sym_out    (sym_out),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .busy       (busy)
`ifdef SYM_SERIALIZER_STARVE_CNT_EN
    ,
    .starve_cnt (starve_cnt)
`endif
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr % 32] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Bounded wait for the read pulse; expiry shows up as a failed check.
  task automatic wait_ren(input string tag);
    int k = 0;
    while (fifo_rEN !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    chk(tag, {31'd0, fifo_rEN}, 32'd1);
  endtask

  // Expect a full word with sym_ready held high, then a return to IDLE.
  task automatic word_ready_high(input string tag, input logic [15:0] w);
    logic [15:0] v;
    v = w;
    wait_ren({tag, "_ren"});
    step();
    chk({tag, "_wait_valid"}, {31'd0, sym_valid}, 32'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_valid"}, {31'd0, sym_valid}, 32'd1);
      chk({tag, "_sym"}, {30'd0, sym_out}, {30'd0, v[15:14]});
      v = v << 2;
      step();
    end
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_valid"}, {31'd0, sym_valid}, 32'd0);
  endtask

  logic [1:0] b4e1_syms [0:7];
  int ren0;

  initial begin
    b4e1_syms[0] = 2'd2; b4e1_syms[1] = 2'd3; b4e1_syms[2] = 2'd1; b4e1_syms[3] = 2'd0;
    b4e1_syms[4] = 2'd3; b4e1_syms[5] = 2'd2; b4e1_syms[6] = 2'd0; b4e1_syms[7] = 2'd1;

    // Reset state
    RST = 1'b1;
    sym_ready = 1'b1;
    step();
    step();
    chk("rst_ren",   {31'd0, fifo_rEN}, 32'd0);
    chk("rst_valid", {31'd0, sym_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_sym",   {30'd0, sym_out}, 32'd0);
    RST = 1'b0;

    // Empty FIFO for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step();
      chk("empty_ren",   {31'd0, fifo_rEN}, 32'd0);
      chk("empty_valid", {31'd0, sym_valid}, 32'd0);
      chk("empty_busy",  {31'd0, busy}, 32'd0);
    end

    // Single word, sym_ready high
    ren0 = ren_cnt;
    push(16'hB4E1);
    word_ready_high("single", 16'hB4E1);
    chk("single_ren_pulses", ren_cnt - ren0, 32'd1);

    // Back-pressure: ready low then high for each symbol, symbol held
    ren0 = ren_cnt;
    push(16'hB4E1);
    wait_ren("bp_ren");
    step();
    step();
    for (int c = 0; c < 16; c++) begin
      sym_ready = (c % 2 == 1) ? 1'b1 : 1'b0;
      chk("bp_valid", {31'd0, sym_valid}, 32'd1);
      chk("bp_sym", {30'd0, sym_out}, {30'd0, b4e1_syms[c / 2]});
      step();
    end
    sym_ready = 1'b1;
    chk("bp_idle_busy", {31'd0, busy}, 32'd0);
    chk("bp_idle_valid", {31'd0, sym_valid}, 32'd0);
    chk("bp_ren_pulses", ren_cnt - ren0, 32'd1);

    // Back-to-back words with exact 2-cycle gap
    ren0 = ren_cnt;
    push(16'hFFFF);
    push(16'h0000);
    wait_ren("b2b_ren");
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      chk("b2b_w0_valid", {31'd0, sym_valid}, 32'd1);
      chk("b2b_w0_sym", {30'd0, sym_out}, 32'd3);
      step();
    end
    chk("b2b_gap0_valid", {31'd0, sym_valid}, 32'd0);
    chk("b2b_gap0_ren", {31'd0, fifo_rEN}, 32'd1);
    chk("b2b_gap0_busy", {31'd0, busy}, 32'd1);
    step();
    chk("b2b_gap1_valid", {31'd0, sym_valid}, 32'd0);
    chk("b2b_gap1_ren", {31'd0, fifo_rEN}, 32'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("b2b_w1_valid", {31'd0, sym_valid}, 32'd1);
      chk("b2b_w1_sym", {30'd0, sym_out}, 32'd0);
      step();
    end
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b_ren_pulses", ren_cnt - ren0, 32'd2);

    // Reset after the third symbol transfers
    push(16'hB4E1);
    wait_ren("rstmid_ren");
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_sym", {30'd0, sym_out}, {30'd0, b4e1_syms[i]});
      step();
    end
    chk("rstmid_sym4_before_rst", {30'd0, sym_out}, {30'd0, b4e1_syms[3]});
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rstmid_valid", {31'd0, sym_valid}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_sym", {30'd0, sym_out}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rstmid_after_valid", {31'd0, sym_valid}, 32'd0);
    end

    // Reset during the REQ cycle: the issued read is dropped
    push(16'hFFFF);
    wait_ren("rstreq_ren");
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rstreq_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rstreq_valid", {31'd0, sym_valid}, 32'd0);
    end

    // Two isolated words, FIFO empty after each
    push(16'hB4E1);
    word_ready_high("iso0", 16'hB4E1);
    step();
    push(16'h1E4B);
    word_ready_high("iso1", 16'h1E4B);
`ifdef SYM_SERIALIZER_STARVE_CNT_EN
    chk("starve_cnt", {16'd0, starve_cnt}, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
